// File: rtl/fixedpoint_wb_buffer_if.sv
// Handshake bundle between the Q7.8 ALU, the writeback buffer and the register-file write port.
// The buffer uses the slave modport. The ALU/register-file side uses the master modport.
interface fixedpoint_wb_buffer_if #(
  parameter int DATA_WIDTH     = 16,
  parameter int REG_ADDR_WIDTH = 4
);
  logic                      ex_valid;
  logic                      ex_ready;
  logic [DATA_WIDTH-1:0]     ex_result;
  logic                      ex_n;
  logic                      ex_v;
  logic                      ex_z;
  logic [REG_ADDR_WIDTH-1:0] ex_rd;
  logic                      wb_valid;
  logic                      wb_ready;
  logic [DATA_WIDTH-1:0]     wb_result;
  logic [REG_ADDR_WIDTH-1:0] wb_rd;

  modport master (
    output ex_valid, ex_result, ex_n, ex_v, ex_z, ex_rd, wb_ready,
    input  ex_ready, wb_valid, wb_result, wb_rd
  );

  modport slave (
    input  ex_valid, ex_result, ex_n, ex_v, ex_z, ex_rd, wb_ready,
    output ex_ready, wb_valid, wb_result, wb_rd
  );
endinterface

// File: rtl/fixedpoint_wb_buffer.sv
// Writeback FIFO between the Q7.8 ALU and the register file.
// It also tracks the retired status flags, a sticky overflow bit and a saturating overflow counter.
module fixedpoint_wb_buffer #(
  parameter int DATA_WIDTH     = 16,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int DEPTH          = 2,
  parameter int CNT_WIDTH      = 8,
  localparam int PTR_W         = $clog2(DEPTH),
  localparam int OCC_W         = PTR_W + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  fixedpoint_wb_buffer_if.slave  bus,
  input  logic                   flush,
  input  logic                   clr_sticky,
  output logic [2:0]             flags_nzv,
  output logic                   sticky_v,
  output logic [CNT_WIDTH-1:0]   ovf_count,
  output logic [OCC_W-1:0]       occupancy
);
  logic [DATA_WIDTH-1:0]     result_mem_r [DEPTH];
  logic [REG_ADDR_WIDTH-1:0] rd_mem_r     [DEPTH];
  logic [DEPTH-1:0]          n_mem_r;
  logic [DEPTH-1:0]          v_mem_r;
  logic [DEPTH-1:0]          z_mem_r;

  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [OCC_W-1:0]     occ_r;
  logic [2:0]           flags_r;
  logic                 sticky_r;
  logic [CNT_WIDTH-1:0] cnt_r;

  logic push_s;
  logic pop_s;
  logic retire_s;
  logic head_v_s;

  // The ready signal depends only on registered occupancy, so a pop never frees a slot in the same cycle.
  assign bus.ex_ready = (occ_r < OCC_W'(DEPTH));
  assign bus.wb_valid = (occ_r != {OCC_W{1'b0}});
  assign push_s       = bus.ex_valid & bus.ex_ready;
  assign pop_s        = bus.wb_valid & bus.wb_ready;
  assign retire_s     = pop_s & ~flush;
  assign head_v_s     = v_mem_r[rd_ptr_r];

  assign bus.wb_result = bus.wb_valid ? result_mem_r[rd_ptr_r] : {DATA_WIDTH{1'b0}};
  assign bus.wb_rd     = bus.wb_valid ? rd_mem_r[rd_ptr_r] : {REG_ADDR_WIDTH{1'b0}};

  assign flags_nzv = flags_r;
  assign sticky_v  = sticky_r;
  assign ovf_count = cnt_r;
  assign occupancy = occ_r;

  // Entry storage. Stale contents are never observable because wb_* are gated by wb_valid.
  always_ff @(posedge clk) begin
    if (push_s) begin
      result_mem_r[wr_ptr_r] <= bus.ex_result;
      rd_mem_r[wr_ptr_r]     <= bus.ex_rd;
      n_mem_r[wr_ptr_r]      <= bus.ex_n;
      v_mem_r[wr_ptr_r]      <= bus.ex_v;
      z_mem_r[wr_ptr_r]      <= bus.ex_z;
    end
  end

  // Pointers and occupancy. A flush beats both a push and a pop in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      occ_r    <= {OCC_W{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + OCC_W'(1);
        2'b01:   occ_r <= occ_r - OCC_W'(1);
        default: occ_r <= occ_r;
      endcase
    end
  end

  // Retire-side status. When an overflowing entry retires in the same cycle as clr_sticky, the set takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_r  <= 3'b010;
      sticky_r <= 1'b0;
      cnt_r    <= {CNT_WIDTH{1'b0}};
    end else begin
      if (retire_s) begin
        flags_r <= {n_mem_r[rd_ptr_r], z_mem_r[rd_ptr_r], head_v_s};
      end
      if (retire_s && head_v_s) begin
        sticky_r <= 1'b1;
        if (clr_sticky) begin
          cnt_r <= CNT_WIDTH'(1);
        end else if (cnt_r != {CNT_WIDTH{1'b1}}) begin
          cnt_r <= cnt_r + CNT_WIDTH'(1);
        end
      end else if (clr_sticky) begin
        sticky_r <= 1'b0;
        cnt_r    <= {CNT_WIDTH{1'b0}};
      end
    end
  end
endmodule

// File: tb/tb_fixedpoint_wb_buffer.sv
// Directed self-checking bench for fixedpoint_wb_buffer.
// Inputs are driven 1 time unit after each rising edge, and outputs are checked at that same point.
module tb_fixedpoint_wb_buffer;
  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       clr_sticky;
  logic [2:0] flags_nzv;
  logic       sticky_v;
  logic [7:0] ovf_count;
  logic [1:0] occupancy;
  int         total  = 0;
  int         passed = 0;

  fixedpoint_wb_buffer_if #(.DATA_WIDTH(16), .REG_ADDR_WIDTH(4)) bus ();

  fixedpoint_wb_buffer #(
    .DATA_WIDTH(16), .REG_ADDR_WIDTH(4), .DEPTH(2), .CNT_WIDTH(8)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .flush(flush), .clr_sticky(clr_sticky),
    .flags_nzv(flags_nzv), .sticky_v(sticky_v), .ovf_count(ovf_count), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive(input logic vld, input logic [15:0] res, input logic n, input logic v,
                       input logic z, input logic [3:0] rd);
    bus.ex_valid  = vld;
    bus.ex_result = res;
    bus.ex_n      = n;
    bus.ex_v      = v;
    bus.ex_z      = z;
    bus.ex_rd     = rd;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_occ"},    32'(occupancy),     32'd0);
    check({tag, "_wbv"},    32'(bus.wb_valid),  32'd0);
    check({tag, "_flags"},  32'(flags_nzv),     32'h2);
    check({tag, "_sticky"}, 32'(sticky_v),      32'd0);
    check({tag, "_cnt"},    32'(ovf_count),     32'd0);
    check({tag, "_wbres"},  32'(bus.wb_result), 32'd0);
    check({tag, "_wbrd"},   32'(bus.wb_rd),     32'd0);
    check({tag, "_exrdy"},  32'(bus.ex_ready),  32'd1);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; clr_sticky = 1'b0; bus.wb_ready = 1'b0;
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd0);
    tick(); tick();
    rst = 1'b0;
    check_reset_state("reset");

    // Single entry, latency 1, then retire
    bus.wb_ready = 1'b1;
    drive(1'b1, 16'h0180, 1'b0, 1'b0, 1'b0, 4'd3);
    tick();
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd0);
    check("t1_wbv", 32'(bus.wb_valid), 32'd1);
    check("t1_res", 32'(bus.wb_result), 32'h0180);
    check("t1_rd", 32'(bus.wb_rd), 32'd3);
    check("t1_flags_pre", 32'(flags_nzv), 32'h2);
    tick();
    check("t1_flags", 32'(flags_nzv), 32'h0);
    check("t1_occ", 32'(occupancy), 32'd0);

    // Back-pressure: third entry held while full
    bus.wb_ready = 1'b0;
    drive(1'b1, 16'h0100, 1'b0, 1'b0, 1'b0, 4'd1); tick();
    drive(1'b1, 16'h0200, 1'b0, 1'b0, 1'b0, 4'd2); tick();
    check("t2_full_rdy", 32'(bus.ex_ready), 32'd0);
    drive(1'b1, 16'h0300, 1'b0, 1'b0, 1'b0, 4'd4); tick();
    check("t2_full_occ", 32'(occupancy), 32'd2);
    check("t2_head_a", 32'(bus.wb_result), 32'h0100);
    bus.wb_ready = 1'b1;
    tick();
    check("t2_occ_after_pop", 32'(occupancy), 32'd1);
    check("t2_head_b", 32'(bus.wb_result), 32'h0200);
    check("t2_rdy", 32'(bus.ex_ready), 32'd1);
    tick();
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd0);
    check("t2_head_c", 32'(bus.wb_result), 32'h0300);
    check("t2_rd_c", 32'(bus.wb_rd), 32'd4);
    check("t2_occ_c", 32'(occupancy), 32'd1);
    tick();
    check("t2_empty", 32'(occupancy), 32'd0);

    // Streaming push+pop at occupancy 1, pointers wrap repeatedly
    drive(1'b1, 16'h1000, 1'b0, 1'b0, 1'b0, 4'd0); tick();
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 16'h1000 + 16'(i), 1'b0, 1'b0, 1'b0, 4'(i));
      tick();
      check($sformatf("t3_occ_%0d", i), 32'(occupancy), 32'd1);
      check($sformatf("t3_res_%0d", i), 32'(bus.wb_result), 32'h1000 + 32'(i));
    end
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd0); tick();
    check("t3_empty", 32'(occupancy), 32'd0);

    // Sticky overflow and counter
    drive(1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0, 4'd5); tick();
    drive(1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 4'd6); tick();
    drive(1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0, 4'd7); tick();
    check("t4_mid_flags", 32'(flags_nzv), 32'h0);
    check("t4_mid_sticky", 32'(sticky_v), 32'd1);
    check("t4_mid_cnt", 32'(ovf_count), 32'd1);
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd0); tick();
    check("t4_flags", 32'(flags_nzv), 32'h1);
    check("t4_sticky", 32'(sticky_v), 32'd1);
    check("t4_cnt", 32'(ovf_count), 32'd2);
    drive(1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0, 4'd8); tick();
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd0);
    clr_sticky = 1'b1; tick(); clr_sticky = 1'b0;
    check("t4_setwins_sticky", 32'(sticky_v), 32'd1);
    check("t4_setwins_cnt", 32'(ovf_count), 32'd1);
    clr_sticky = 1'b1; tick(); clr_sticky = 1'b0;
    check("t4_clr_sticky", 32'(sticky_v), 32'd0);
    check("t4_clr_cnt", 32'(ovf_count), 32'd0);
    check("t4_clr_flags", 32'(flags_nzv), 32'h1);

    // Counter saturation: 300 overflowing retirements
    drive(1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0, 4'd9);
    for (int i = 0; i < 300; i++) tick();
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd0); tick();
    check("t5_cnt_sat", 32'(ovf_count), 32'd255);
    check("t5_sticky", 32'(sticky_v), 32'd1);

    // Flags are stored verbatim, independent of the result value
    drive(1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 4'd2); tick();
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd0); tick();
    check("t6_verbatim_flags", 32'(flags_nzv), 32'h4);

    // Flush beats a same-cycle push and pop
    bus.wb_ready = 1'b0;
    drive(1'b1, 16'h8000, 1'b1, 1'b1, 1'b0, 4'd10); tick();
    drive(1'b1, 16'h8001, 1'b1, 1'b1, 1'b0, 4'd11); tick();
    check("t6_full", 32'(occupancy), 32'd2);
    drive(1'b1, 16'h0055, 1'b0, 1'b1, 1'b0, 4'd12);
    bus.wb_ready = 1'b1; flush = 1'b1; tick(); flush = 1'b0;
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd0);
    check("t6_flush_occ", 32'(occupancy), 32'd0);
    check("t6_flush_wbv", 32'(bus.wb_valid), 32'd0);
    check("t6_flush_flags", 32'(flags_nzv), 32'h4);
    check("t6_flush_sticky", 32'(sticky_v), 32'd1);
    check("t6_flush_cnt", 32'(ovf_count), 32'd255);
    drive(1'b1, 16'h0066, 1'b0, 1'b0, 1'b0, 4'd13);
    flush = 1'b1; tick(); flush = 1'b0;
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd0);
    check("t6_flush_push_dropped", 32'(occupancy), 32'd0);

    // Reset with a full buffer
    bus.wb_ready = 1'b0;
    drive(1'b1, 16'h0A0A, 1'b0, 1'b1, 1'b0, 4'd14); tick();
    drive(1'b1, 16'h0B0B, 1'b0, 1'b1, 1'b0, 4'd15); tick();
    check("t7_full", 32'(occupancy), 32'd2);
    bus.wb_ready = 1'b1; rst = 1'b1; tick(); rst = 1'b0;
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd0);
    bus.wb_ready = 1'b0;
    check_reset_state("t7_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
